data_mem: RTL and testbench
===========================

# data_mem

Memory-stage data memory for the five-stage MIPS pipeline. Sits directly downstream of the execute stage. Takes the execute-stage ALU result as the byte address, the forwarded rt value as store data, and the instruction word carried down the pipe. Performs word, halfword and byte stores with byte enables and returns sign- or zero-extended load data to the M/W pipeline register.

## Interface
Parameters:
- ADDR_W, 12, word-index width; memory holds 2^ADDR_W 32-bit words (4096 words = 16 KB)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears entire memory
- instr  input  32  instruction in M stage; opcode instr[31:26] selects the access
- addr  input  32  byte address (execute-stage ALU result)
- wdata  input  32  store data (rt, already forwarded)
- rdata  output  32  extended load data; 0 for non-load instructions
- be  output  4  byte enables of the current store; 4'b0000 when not a store

## Operation
- Opcode decode:
  - lw 100011
  - lh 100001
  - lhu 100101
  - lb 100000
  - lbu 100100
  - sw 101011
  - sh 101001
  - sb 101000
  - Any other opcode is neither load nor store.
- Word index = addr[ADDR_W+1:2].
  - Upper address bits are ignored, so the address wraps modulo 2^(ADDR_W+2).
  - Alignment is not checked.
  - lw/sw ignore addr[1:0]; lh/lhu/sh ignore addr[0].
- Byte lanes are little-endian; byte k is word[8k+7:8k].
- Byte enables:
  - sw: 1111
  - sh: addr[1]=0 gives 0011, addr[1]=1 gives 1100
  - sb: 0001 << addr[1:0]
- Store: on posedge clk with reset=0, each enabled lane of mem[index] takes the same lane of the store value. Disabled lanes keep their contents.
- Store value placement:
  - sw: wdata
  - sh: {2{wdata[15:0]}}
  - sb: {4{wdata[7:0]}}
- Load (combinational from the array): word = mem[index].
  - lw: word
  - lh / lhu: halfword at lane addr[1], sign- / zero-extended
  - lb / lbu: byte at lane addr[1:0], sign- / zero-extended
- rdata = 0 and be = 0 for every non-memory instruction. Stores also drive rdata = 0.

## Timing
- Reset:
  - Synchronous. At a posedge with reset=1, every word becomes 32'h0.
  - Reset overrides any store presented in the same cycle.
  - After that edge, every load returns 0.
- Outputs:
  - rdata and be have no reset value of their own; they are combinational functions of instr, addr and array contents.
  - At reset they read 0 whenever the instruction is not a memory operation.
- Load latency: 0 cycles. rdata is valid in the same cycle instr/addr are presented and is captured by the M/W register at the next edge.
- Store latency: 1 edge. The array updates at the posedge ending the cycle in which the store is in M.
- Store then load, same word, consecutive cycles: the load sees the post-store value.
- A store in cycle N does not change rdata within cycle N; rdata reflects the old contents until the edge.
- No stall input. The pipeline presents a bubble (instr = 0, i.e. sll $0) to suppress access; a bubble never writes.

## Test plan
- **Reset clear:** sw 0x12345678 to addr 0x10. Assert reset one cycle. Then lw 0x10 -> rdata = 0x00000000.
- **Word path and wrap:**
  - sw 0xDEADBEEF to addr 0x0000_0004.
  - lw 0x4 -> 0xDEADBEEF.
  - lw 0x0001_0004 (wraps with ADDR_W=12) -> 0xDEADBEEF.
  - lw 0x7 -> 0xDEADBEEF (low bits ignored).
- **Byte lanes:**
  - After sw 0 to 0x20, sb wdata=0x000000A5 to 0x22 -> be = 0100.
  - Then lw 0x20 -> 0x00A50000.
  - lb 0x22 -> 0xFFFFFFA5.
  - lbu 0x22 -> 0x000000A5.
  - lb 0x21 -> 0x00000000.
- **Halfword lanes:**
  - sw 0x11223344 to 0x30, then sh wdata=0xFFFF8001 to 0x32 -> be = 1100.
  - lw 0x30 -> 0x80013344.
  - lh 0x32 -> 0xFFFF8001.
  - lhu 0x32 -> 0x00008001.
  - lh 0x30 -> 0x00003344.
- **Reset vs store collision:** assert reset in the same cycle as sw 0xCAFEBABE to 0x40. Then lw 0x40 -> 0x00000000.
- **Back-to-back and non-memory ops:**
  - sw 0x1 to 0x50 in cycle N, then lw 0x50 in cycle N+1 -> 0x00000001.
  - During cycle N, rdata = 0 and be = 1111.
  - An addu instruction with addr=0x50 -> rdata = 0, be = 0000, memory unchanged.

Source files
------------

// File: rtl/data_mem.sv
// Memory-stage data memory: byte-enabled word/half/byte stores and
// sign/zero-extended combinational loads for the five-stage MIPS pipe.
module data_mem #(
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [3:0]  be
);

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101,
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SW  = 6'b101011
  } op_e;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] index;
  logic [31:0]       word;
  logic [15:0]       half;
  logic [7:0]        lane;
  logic [31:0]       store_val;

  // Upper address bits wrap away; the rest of instr is decoded elsewhere.
  logic unused_ok;
  assign unused_ok = ^{instr[25:0], addr[31:ADDR_W+2]};

  assign index = addr[ADDR_W+1:2];
  assign word  = mem[index];
  assign half  = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    lane = word[7:0];
    unique case (addr[1:0])
      2'd0: lane = word[7:0];
      2'd1: lane = word[15:8];
      2'd2: lane = word[23:16];
      2'd3: lane = word[31:24];
    endcase
  end

  // Store decode: lane enables plus the value replicated into every lane.
  always_comb begin
    be        = 4'b0000;
    store_val = 32'h0;
    case (instr[31:26])
      OP_SW: begin
        be        = 4'b1111;
        store_val = wdata;
      end
      OP_SH: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        store_val = {2{wdata[15:0]}};
      end
      OP_SB: begin
        be        = 4'b0001 << addr[1:0];
        store_val = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    case (instr[31:26])
      OP_LW:   rdata = word;
      OP_LH:   rdata = {{16{half[15]}}, half};
      OP_LHU:  rdata = {16'h0, half};
      OP_LB:   rdata = {{24{lane[7]}}, lane};
      OP_LBU:  rdata = {24'h0, lane};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the array is held in flops rather than a RAM macro because the
    // pipeline relies on a single-edge clear of every word; a RAM cannot reset.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every lane
      // update reads pre-edge values regardless of statement order.
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[index][8*k +: 8] <= store_val[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized
// traffic compared against a byte-addressed reference memory.
module tb_data_mem;

  localparam int ADDR_W = 12;
  localparam int MB     = 1 << (ADDR_W + 2);

  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011,
                         LBU = 6'b100100, LHU = 6'b100101,
                         SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
  localparam logic [31:0] ADDU_I = 32'h00A51021;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0, addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [3:0]  be;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rdata;
  logic [3:0]  last_be;

  bit [7:0] mb [MB];

  data_mem #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .instr(instr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .be(be)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: memory as a flat little-endian byte array.
  function automatic int bidx(input logic [31:0] a);
    return int'(a[ADDR_W+1:0]);
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] i, input logic [31:0] a);
    int b;
    logic [15:0] h;
    logic [7:0]  y;
    case (i[31:26])
      LW: begin
        b = bidx(a) & ~3;
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      end
      LH, LHU: begin
        b = bidx(a) & ~1;
        h = {mb[b+1], mb[b]};
        return (i[31:26] == LH) ? {{16{h[15]}}, h} : {16'h0, h};
      end
      LB, LBU: begin
        y = mb[bidx(a)];
        return (i[31:26] == LB) ? {{24{y[7]}}, y} : {24'h0, y};
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] i, input logic [31:0] a);
    case (i[31:26])
      SW:      return 4'b1111;
      SH:      return (a[1] == 1'b0) ? 4'b0011 : 4'b1100;
      SB:      return 4'(1 << a[1:0]);
      default: return 4'b0000;
    endcase
  endfunction

  task automatic m_store(input logic [31:0] i, input logic [31:0] a, input logic [31:0] d);
    int b;
    case (i[31:26])
      SW: begin
        b = bidx(a) & ~3;
        for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
      end
      SH: begin
        b = bidx(a) & ~1;
        mb[b] = d[7:0];
        mb[b+1] = d[15:8];
      end
      SB: mb[bidx(a)] = d[7:0];
      default: ;
    endcase
  endtask

  // One pipeline cycle: drive after an edge, compare mid-cycle, commit at edge.
  task automatic apply(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] d, input bit r);
    instr = i; addr = a; wdata = d; reset = r;
    @(negedge clk);
    last_rdata = rdata;
    last_be    = be;
    if (!r) begin
      check("rdata_model", rdata, m_rdata(i, a));
      check("be_model", {28'h0, be}, {28'h0, m_be(i, a)});
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < MB; k++) mb[k] = 8'h0;
    end else begin
      m_store(i, a, d);
    end
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op);
    return {op, 26'($urandom)};
  endfunction

  initial begin
    logic [5:0] ops [10];
    logic [31:0] a, i;
    ops = '{LW, LH, LHU, LB, LBU, SW, SH, SB, 6'b000000, 6'b001000};

    @(posedge clk); #1;
    apply(32'h0, 32'h0, 32'h0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      apply(mk(LW), $urandom, 32'h0, 1'b0);
      check("reset_state_lw", last_rdata, 32'h0);
    end

    // Reset clear
    apply(mk(SW), 32'h10, 32'h12345678, 1'b0);
    apply(32'h0, 32'h0, 32'h0, 1'b1);
    apply(mk(LW), 32'h10, 32'h0, 1'b0);
    check("reset_clear", last_rdata, 32'h0);

    // Word path and wrap
    apply(mk(SW), 32'h4, 32'hDEADBEEF, 1'b0);
    apply(mk(LW), 32'h4, 32'h0, 1'b0);
    check("lw_word", last_rdata, 32'hDEADBEEF);
    apply(mk(LW), 32'h0001_0004, 32'h0, 1'b0);
    check("lw_wrap", last_rdata, 32'hDEADBEEF);
    apply(mk(LW), 32'h7, 32'h0, 1'b0);
    check("lw_lowbits", last_rdata, 32'hDEADBEEF);

    // Byte lanes
    apply(mk(SW), 32'h20, 32'h0, 1'b0);
    apply(mk(SB), 32'h22, 32'h000000A5, 1'b0);
    check("sb_be", {28'h0, last_be}, 32'h4);
    apply(mk(LW), 32'h20, 32'h0, 1'b0);
    check("sb_word", last_rdata, 32'h00A50000);
    apply(mk(LB), 32'h22, 32'h0, 1'b0);
    check("lb_sext", last_rdata, 32'hFFFFFFA5);
    apply(mk(LBU), 32'h22, 32'h0, 1'b0);
    check("lbu_zext", last_rdata, 32'h000000A5);
    apply(mk(LB), 32'h21, 32'h0, 1'b0);
    check("lb_other_lane", last_rdata, 32'h0);

    // Halfword lanes
    apply(mk(SW), 32'h30, 32'h11223344, 1'b0);
    apply(mk(SH), 32'h32, 32'hFFFF8001, 1'b0);
    check("sh_be", {28'h0, last_be}, 32'hC);
    apply(mk(LW), 32'h30, 32'h0, 1'b0);
    check("sh_word", last_rdata, 32'h80013344);
    apply(mk(LH), 32'h32, 32'h0, 1'b0);
    check("lh_sext", last_rdata, 32'hFFFF8001);
    apply(mk(LHU), 32'h32, 32'h0, 1'b0);
    check("lhu_zext", last_rdata, 32'h00008001);
    apply(mk(LH), 32'h30, 32'h0, 1'b0);
    check("lh_low", last_rdata, 32'h00003344);

    // Reset vs store collision
    apply(mk(SW), 32'h40, 32'hCAFEBABE, 1'b1);
    apply(mk(LW), 32'h40, 32'h0, 1'b0);
    check("reset_beats_store", last_rdata, 32'h0);

    // Back-to-back and non-memory ops
    apply(mk(SW), 32'h50, 32'h1, 1'b0);
    check("store_rdata", last_rdata, 32'h0);
    check("store_be", {28'h0, last_be}, 32'hF);
    apply(mk(LW), 32'h50, 32'h0, 1'b0);
    check("b2b_load", last_rdata, 32'h1);
    apply(ADDU_I, 32'h50, 32'hFFFFFFFF, 1'b0);
    check("addu_rdata", last_rdata, 32'h0);
    check("addu_be", {28'h0, last_be}, 32'h0);
    apply(32'h0, 32'h50, 32'hFFFFFFFF, 1'b0);
    check("bubble_be", {28'h0, last_be}, 32'h0);
    apply(mk(LW), 32'h50, 32'h0, 1'b0);
    check("addu_no_write", last_rdata, 32'h1);

    // Randomized traffic concentrated on a small window to force overlap
    for (int n = 0; n < 3000; n++) begin
      i = mk(ops[$urandom_range(0, 9)]);
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
      apply(i, a, $urandom, ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
